// File: rtl/sprite_renderer.sv
// Two-stage sprite renderer: per-frame shadowed sprite state, 12x8 bitmap at 4x scale, hit flash.
// Optional screen border overlay is built when SPRITE_BORDER_EN is defined.
module sprite_renderer #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int BOX_W    = 48,
  parameter int BOX_H    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       display_on,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic [9:0] posx,
  input  logic [8:0] posy,
  input  logic [2:0] color_idx,
  input  logic [7:0] hits,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       sprite_px
);

  logic [9:0] sx;
  logic [8:0] sy;
  logic [2:0] scol;
  logic [7:0] last_hits;
  logic [3:0] flash;

  // Shadows only move on frame_tick so a frame is always drawn from one consistent state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx        <= '0;
      sy        <= '0;
      scol      <= '0;
      last_hits <= '0;
      flash     <= '0;
    end else if (frame_tick) begin
      sx        <= posx;
      sy        <= posy;
      scol      <= color_idx;
      last_hits <= hits;
      if (hits != last_hits)
        flash <= 4'd15;
      else if (flash != 4'd0)
        flash <= flash - 4'd1;
    end
  end

  logic signed [10:0] dx_n;
  logic signed [10:0] dy_n;
  logic               in_box_n;

  always_comb begin
    dx_n     = $signed({1'b0, hpos}) - $signed({2'b00, sx});
    dy_n     = $signed({1'b0, vpos}) - $signed({2'b00, sy});
    in_box_n = !dx_n[10] && (dx_n[9:0] < 10'(BOX_W)) &&
               !dy_n[10] && (dy_n[9:0] < 10'(BOX_H));
  end

  logic [3:0] col1;
  logic [2:0] row1;
  logic       in_box1;
  logic       de1;
  logic [2:0] scol1;
  logic       white1;
`ifdef SPRITE_BORDER_EN
  logic       border1;
`endif

  // Colour and flash state ride along with the pixel, so a pixel sampled on the tick cycle
  // is drawn entirely from the pre-update shadows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col1    <= '0;
      row1    <= '0;
      in_box1 <= 1'b0;
      de1     <= 1'b0;
      scol1   <= '0;
      white1  <= 1'b0;
`ifdef SPRITE_BORDER_EN
      border1 <= 1'b0;
`endif
    end else begin
      col1    <= dx_n[5:2];
      row1    <= dy_n[4:2];
      in_box1 <= in_box_n;
      de1     <= display_on;
      scol1   <= scol;
      white1  <= (flash != 4'd0) && flash[1];
`ifdef SPRITE_BORDER_EN
      border1 <= (hpos == 10'd0) || (hpos == 10'(SCREEN_W - 1)) ||
                 (vpos == 10'd0) || (vpos == 10'(SCREEN_H - 1));
`endif
    end
  end

  function automatic logic bitmap_bit(input logic [3:0] col, input logic [2:0] row);
    logic [11:0] bits;
    case (row)
      3'd0:    bits = 12'h0F0;
      3'd1:    bits = 12'h1F8;
      3'd2:    bits = 12'hFFE;
      3'd3:    bits = 12'hFFF;
      3'd4:    bits = 12'h7FE;
      3'd5:    bits = 12'h3FC;
      3'd6:    bits = 12'h606;
      default: bits = 12'hC03;
    endcase
    if (col > 4'd11)
      return 1'b0;
    return bits[4'd11 - col];
  endfunction

  logic [1:0] r_n, g_n, b_n;
  logic       sprite_n;
  logic       opaque;

  always_comb begin
    r_n      = 2'd0;
    g_n      = 2'd0;
    b_n      = 2'd0;
    sprite_n = 1'b0;
    opaque   = in_box1 && bitmap_bit(col1, row1) && (scol1 != 3'd0);
    if (de1) begin
`ifdef SPRITE_BORDER_EN
      if (border1) begin
        r_n = 2'd3;
        g_n = 2'd3;
        b_n = 2'd3;
      end else
`endif
      if (opaque) begin
        sprite_n = 1'b1;
        if (white1) begin
          r_n = 2'd3;
          g_n = 2'd3;
          b_n = 2'd3;
        end else begin
          r_n = {2{scol1[0]}};
          g_n = {2{scol1[1]}};
          b_n = {2{scol1[2]}};
        end
      end else begin
        b_n = 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      sprite_px <= 1'b0;
    end else begin
      r         <= r_n;
      g         <= g_n;
      b         <= b_n;
      sprite_px <= sprite_n;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed self-checking bench for sprite_renderer; outputs compared as {sprite_px,r,g,b}.
module tb_sprite_renderer;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic [9:0] posx;
  logic [8:0] posy;
  logic [2:0] color_idx;
  logic [7:0] hits;
  logic [1:0] r, g, b;
  logic       sprite_px;

  int checks;
  int failures;

  localparam logic [6:0] BLACK = 7'b0_00_00_00;
  localparam logic [6:0] BG    = 7'b0_00_00_01;
  localparam logic [6:0] RED   = 7'b1_11_00_00;
  localparam logic [6:0] WHITE = 7'b1_11_11_11;
  localparam logic [6:0] CYAN  = 7'b1_00_11_11;
  localparam logic [6:0] FRAME = 7'b0_11_11_11;

  sprite_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
    .posx       (posx),
    .posy       (posy),
    .color_idx  (color_idx),
    .hits       (hits),
    .r          (r),
    .g          (g),
    .b          (b),
    .sprite_px  (sprite_px)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [6:0] actual, input logic [6:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got {px,r,g,b}=%b required %b", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v, input logic de);
    hpos       = h;
    vpos       = v;
    display_on = de;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic pixelCheck(input string tag, input logic [9:0] h, input logic [9:0] v,
                            input logic de, input logic [6:0] expected);
    applyStimulus(h, v, de);
    checkOutput(tag, {sprite_px, r, g, b}, expected);
  endtask

  task automatic frameTick(input logic [9:0] px, input logic [8:0] py,
                           input logic [2:0] col, input logic [7:0] ht);
    posx       = px;
    posy       = py;
    color_idx  = col;
    hits       = ht;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  initial begin
    logic [3:0] fl;
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    display_on = 1'b1;
    hpos       = 10'd104;
    vpos       = 10'd112;
    posx       = 10'd100;
    posy       = 9'd100;
    color_idx  = 3'd1;
    hits       = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {sprite_px, r, g, b}, BLACK);
    @(negedge clk);
    rst_n = 1'b1;

    // Before the first tick the sprite is invisible at (0,0).
    pixelCheck("pre_tick_origin", 10'd4, 10'd12, 1'b1, BG);

    frameTick(10'd100, 9'd100, 3'd1, 8'd0);
    pixelCheck("row0_col4_on",   10'd116, 10'd100, 1'b1, RED);
    pixelCheck("row0_col0_off",  10'd100, 10'd100, 1'b1, BG);
    pixelCheck("row0_col1_off",  10'd104, 10'd100, 1'b1, BG);
    pixelCheck("row3_col11_on",  10'd147, 10'd112, 1'b1, RED);
    pixelCheck("dx48_outside",   10'd148, 10'd112, 1'b1, BG);
    pixelCheck("dx_neg_outside", 10'd99,  10'd112, 1'b1, BG);
    pixelCheck("row7_col0_on",   10'd100, 10'd131, 1'b1, RED);
    pixelCheck("dy32_outside",   10'd100, 10'd132, 1'b1, BG);

    posx = 10'd300;
    pixelCheck("no_tear_old_pos", 10'd104, 10'd112, 1'b1, RED);
    pixelCheck("no_tear_new_pos", 10'd300, 10'd112, 1'b1, BG);
    frameTick(10'd300, 9'd100, 3'd1, 8'd0);
    pixelCheck("moved_new_pos", 10'd300, 10'd112, 1'b1, RED);
    pixelCheck("moved_old_pos", 10'd104, 10'd112, 1'b1, BG);

    frameTick(10'd300, 9'd100, 3'd1, 8'd1);
    pixelCheck("flash_15", 10'd300, 10'd112, 1'b1, WHITE);
    fl = 4'd15;
    for (int n = 1; n <= 15; n++) begin
      frameTick(10'd300, 9'd100, 3'd1, 8'd1);
      fl = fl - 4'd1;
      pixelCheck($sformatf("flash_%0d", fl), 10'd300, 10'd112, 1'b1, fl[1] ? WHITE : RED);
    end
    frameTick(10'd300, 9'd100, 3'd1, 8'd1);
    pixelCheck("flash_idle", 10'd300, 10'd112, 1'b1, RED);

    frameTick(10'd300, 9'd100, 3'd1, 8'd0);
    pixelCheck("hits_decrease_flash", 10'd300, 10'd112, 1'b1, WHITE);
    repeat (15) frameTick(10'd300, 9'd100, 3'd1, 8'd0);

    frameTick(10'd300, 9'd100, 3'd0, 8'd0);
    pixelCheck("colour0_transparent", 10'd300, 10'd112, 1'b1, BG);
    frameTick(10'd300, 9'd100, 3'd6, 8'd0);
    pixelCheck("colour6", 10'd300, 10'd112, 1'b1, CYAN);
    pixelCheck("display_off", 10'd300, 10'd112, 1'b0, BLACK);

    // Pixel in stage 1 on the tick cycle still sees the old position.
    hpos       = 10'd300;
    vpos       = 10'd112;
    display_on = 1'b1;
    posx       = 10'd500;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    hpos       = 10'd0;
    @(posedge clk);
    #1;
    checkOutput("tick_same_cycle", {sprite_px, r, g, b}, CYAN);
    pixelCheck("tick_new_pos", 10'd500, 10'd112, 1'b1, CYAN);

    frameTick(10'd620, 9'd470, 3'd1, 8'd0);
    pixelCheck("right_edge_drawn", 10'd638, 10'd482 - 10'd0 - 10'd0, 1'b1, RED);
`ifdef SPRITE_BORDER_EN
    pixelCheck("no_wrap_left", 10'd0, 10'd482, 1'b1, FRAME);
    pixelCheck("border_top", 10'd200, 10'd0, 1'b1, FRAME);
`else
    pixelCheck("no_wrap_left", 10'd0, 10'd482, 1'b1, BG);
    pixelCheck("no_wrap_top", 10'd638, 10'd0, 1'b1, BG);
`endif

    applyStimulus(10'd638, 10'd482, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {sprite_px, r, g, b}, BLACK);
    @(negedge clk);
    rst_n = 1'b1;
    pixelCheck("after_reset_invisible", 10'd638, 10'd482, 1'b1, BG);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
